// File: rtl/cpu_fwd_pkg.sv
// Shared forwarding definitions for the hazard/forwarding control unit and the
// operand forwarding stage.
package cpu_fwd_pkg;

  localparam int FWD_REG = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_ALU = 2;

  // Width of the select field for the baseline three-source configuration.
  localparam int FWD_NSRC_BASE = 3;

  typedef logic [$clog2(FWD_NSRC_BASE)-1:0] fwd_sel_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  function automatic int fwd_selw(input int nsrc);
    return (nsrc > 2) ? $clog2(nsrc) : 1;
  endfunction

  function automatic logic fwd_sel_legal(input int sel, input int nsrc);
    return (sel < nsrc);
  endfunction

endpackage

// File: rtl/operand_fwd_reg_if.sv
// Operand forwarding stage bus: packed sources + select in, registered operand out.
interface operand_fwd_reg_if
  import cpu_fwd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSRC  = 3,
  parameter int SELW  = fwd_selw(NSRC)
);

  logic [NSRC*WIDTH-1:0] data_i;
  logic [SELW-1:0]       select_i;
  logic                  valid_i;
  logic                  ready_o;
  logic                  flush_i;
  logic [WIDTH-1:0]      data_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  sel_err_o;

  modport slave (
    input  data_i, select_i, valid_i, flush_i, ready_i,
    output ready_o, data_o, valid_o, sel_err_o
  );

  modport master (
    output data_i, select_i, valid_i, flush_i, ready_i,
    input  ready_o, data_o, valid_o, sel_err_o
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer with synchronous flush; ready toward upstream depends
// only on buffer state, never on the downstream ready.
module pipe_skid_buf
  import cpu_fwd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy
);

  skid_state_e      state_p1, state_d;
  logic [WIDTH-1:0] main_data_p1, main_data_d;
  logic [WIDTH-1:0] skid_data_p1, skid_data_d;
  logic             accept_p0;

  assign in_rdy   = (state_p1 != SKID_FULL);
  assign out_vld  = (state_p1 != SKID_EMPTY);
  assign out_data = main_data_p1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_p1     <= SKID_EMPTY;
      main_data_p1 <= '0;
      skid_data_p1 <= '0;
    end else begin
      state_p1     <= state_d;
      main_data_p1 <= main_data_d;
      skid_data_p1 <= skid_data_d;
    end
  end

  // Main entry always drives the output; skid only fills when main is stalled.
  always_comb begin
    state_d     = state_p1;
    main_data_d = main_data_p1;
    skid_data_d = skid_data_p1;
    accept_p0   = in_vld & in_rdy;
    if (flush_i) begin
      state_d = SKID_EMPTY;
    end else begin
      unique case (state_p1)
        SKID_EMPTY: begin
          if (accept_p0) begin
            main_data_d = in_data;
            state_d     = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept_p0) begin
            if (out_rdy) begin
              main_data_d = in_data;
            end else begin
              skid_data_d = in_data;
              state_d     = SKID_FULL;
            end
          end else if (out_rdy) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (out_rdy) begin
            main_data_d = skid_data_p1;
            state_d     = SKID_ONE;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/operand_fwd_reg.sv
// Operand forwarding stage: selects one of NSRC sources (falling back to the
// last legal operand on a bad select) and registers it behind a skid buffer.
module operand_fwd_reg
  import cpu_fwd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSRC  = 3,
  parameter int SELW  = fwd_selw(NSRC)
) (
  input logic               clk_i,
  input logic               rst_i,
  operand_fwd_reg_if.slave  bus
);

  logic [WIDTH-1:0] sel_data_p0;
  logic             sel_legal_p0;
  logic             accept_p0;
  logic             buf_rdy;
  logic [WIDTH-1:0] last_q;
  logic             err_p1;

  // Stage 0: source mux; an out-of-range select replays the last legal operand.
  always_comb begin
    sel_data_p0 = last_q;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(bus.select_i) == k) begin
        sel_data_p0 = bus.data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign sel_legal_p0 = fwd_sel_legal(int'(bus.select_i), NSRC);
  assign accept_p0    = bus.valid_i & buf_rdy;
  assign bus.ready_o  = buf_rdy;

  // Stage 1: hold register and error pulse; last_q survives a flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= '0;
      err_p1 <= 1'b0;
    end else begin
      if (accept_p0 && sel_legal_p0) begin
        last_q <= sel_data_p0;
      end
      err_p1 <= accept_p0 & ~sel_legal_p0 & ~bus.flush_i;
    end
  end

  assign bus.sel_err_o = err_p1;

  pipe_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (bus.flush_i),
    .in_data  (sel_data_p0),
    .in_vld   (bus.valid_i),
    .in_rdy   (buf_rdy),
    .out_data (bus.data_o),
    .out_vld  (bus.valid_o),
    .out_rdy  (bus.ready_i)
  );

endmodule

// File: tb/tb_operand_fwd_reg.sv
// Bench for operand_fwd_reg: a queue-based model for a 3x32 and a 5x64 build,
// checked every cycle, plus directed literal expectations.
module tb_operand_fwd_reg;
  import cpu_fwd_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  operand_fwd_reg_if #(.WIDTH(32), .NSRC(3)) ia ();
  operand_fwd_reg_if #(.WIDTH(64), .NSRC(5)) ib ();

  operand_fwd_reg #(.WIDTH(32), .NSRC(3)) dut_a (.clk_i(clk_i), .rst_i(rst_i), .bus(ia));
  operand_fwd_reg #(.WIDTH(64), .NSRC(5)) dut_b (.clk_i(clk_i), .rst_i(rst_i), .bus(ib));

  logic [31:0] src_a [4];
  logic [63:0] src_b [8];
  assign ia.data_i = {src_a[2], src_a[1], src_a[0]};
  assign ib.data_i = {src_b[4], src_b[3], src_b[2], src_b[1], src_b[0]};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Model: the stage is a FIFO of depth 2 with a replay register.
  logic [31:0] qa[$];
  logic [63:0] qb[$];
  int          cnt_a = 0, cnt_b = 0;
  logic [31:0] last_a = '0;
  logic [63:0] last_b = '0;
  logic        err_a = 1'b0, err_b = 1'b0;
  logic        acc_a, acc_b, legal_a, legal_b;
  logic [31:0] val_a;
  logic [63:0] val_b;

  assign legal_a = (ia.select_i < 2'd3);
  assign legal_b = (ib.select_i < 3'd5);
  assign acc_a   = ia.valid_i && (cnt_a < 2);
  assign acc_b   = ib.valid_i && (cnt_b < 2);
  assign val_a   = legal_a ? src_a[ia.select_i] : last_a;
  assign val_b   = legal_b ? src_b[ib.select_i] : last_b;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      qa.delete();
      cnt_a  <= 0;
      last_a <= '0;
      err_a  <= 1'b0;
    end else begin
      err_a <= acc_a && !legal_a && !ia.flush_i;
      if (acc_a && legal_a) last_a <= val_a;
      if (ia.flush_i) qa.delete();
      else begin
        if (qa.size() != 0 && ia.ready_i) void'(qa.pop_front());
        if (acc_a) qa.push_back(val_a);
      end
      cnt_a <= qa.size();
    end
  end

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      qb.delete();
      cnt_b  <= 0;
      last_b <= '0;
      err_b  <= 1'b0;
    end else begin
      err_b <= acc_b && !legal_b && !ib.flush_i;
      if (acc_b && legal_b) last_b <= val_b;
      if (ib.flush_i) qb.delete();
      else begin
        if (qb.size() != 0 && ib.ready_i) void'(qb.pop_front());
        if (acc_b) qb.push_back(val_b);
      end
      cnt_b <= qb.size();
    end
  end

  always @(negedge clk_i) begin
    chk("a_valid", ia.valid_o, cnt_a > 0);
    chk("a_ready", ia.ready_o, cnt_a < 2);
    chk("a_err", ia.sel_err_o, err_a);
    if (qa.size() > 0) chk("a_data", ia.data_o, qa[0]);
    chk("b_valid", ib.valid_o, cnt_b > 0);
    chk("b_ready", ib.ready_o, cnt_b < 2);
    chk("b_err", ib.sel_err_o, err_b);
    if (qb.size() > 0) chk("b_data", ib.data_o, qb[0]);
  end

  task automatic step_a(input logic v, input logic [1:0] sel, input logic r, input logic f);
    ia.valid_i  = v;
    ia.select_i = sel;
    ia.ready_i  = r;
    ia.flush_i  = f;
    @(negedge clk_i);
  endtask

  task automatic step_b(input logic v, input logic [2:0] sel, input logic r);
    ib.valid_i  = v;
    ib.select_i = sel;
    ib.ready_i  = r;
    @(negedge clk_i);
  endtask

  initial begin
    ia.valid_i = 1'b0; ia.select_i = '0; ia.ready_i = 1'b1; ia.flush_i = 1'b0;
    ib.valid_i = 1'b0; ib.select_i = '0; ib.ready_i = 1'b1; ib.flush_i = 1'b0;
    src_a[0] = 32'h11; src_a[1] = 32'h22; src_a[2] = 32'h33; src_a[3] = 32'h0;
    for (int k = 0; k < 8; k++) src_b[k] = 64'h1000_0000_0000_0000 + 64'(k);
    src_b[4] = 64'hDEAD_BEEF_0000_0001;

    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_valid", ia.valid_o, 1'b0);
    chk("rst_ready", ia.ready_o, 1'b1);
    chk("rst_err", ia.sel_err_o, 1'b0);
    chk("rst_data", ia.data_o, 64'h0);

    // Streaming with the downstream always ready.
    step_a(1'b1, 2'(FWD_REG), 1'b1, 1'b0);
    chk("lit_stream_reg", ia.data_o, 64'h11);
    step_a(1'b1, 2'(FWD_MEM), 1'b1, 1'b0);
    chk("lit_stream_mem", ia.data_o, 64'h22);
    chk("lit_stream_rdy", ia.ready_o, 1'b1);
    step_a(1'b1, 2'(FWD_ALU), 1'b1, 1'b0);
    chk("lit_stream_alu", ia.data_o, 64'h33);
    chk("lit_stream_vld", ia.valid_o, 1'b1);
    step_a(1'b0, 2'd0, 1'b1, 1'b0);
    chk("lit_drain_vld", ia.valid_o, 1'b0);

    // Backpressure: third operand must wait upstream.
    src_a[0] = 32'hA0;
    step_a(1'b1, 2'd0, 1'b0, 1'b0);
    chk("lit_bp_rdy1", ia.ready_o, 1'b1);
    src_a[0] = 32'hA1;
    step_a(1'b1, 2'd0, 1'b0, 1'b0);
    chk("lit_bp_rdy2", ia.ready_o, 1'b0);
    chk("lit_bp_hold", ia.data_o, 64'hA0);
    src_a[0] = 32'hA2;
    step_a(1'b1, 2'd0, 1'b0, 1'b0);
    chk("lit_bp_hold2", ia.data_o, 64'hA0);
    step_a(1'b1, 2'd0, 1'b1, 1'b0);
    chk("lit_bp_a1", ia.data_o, 64'hA1);
    step_a(1'b1, 2'd0, 1'b1, 1'b0);
    chk("lit_bp_a2", ia.data_o, 64'hA2);
    step_a(1'b0, 2'd0, 1'b1, 1'b0);
    chk("lit_bp_empty", ia.valid_o, 1'b0);

    // Illegal select replays the last legal operand.
    src_a[0] = 32'h55;
    step_a(1'b1, 2'd0, 1'b1, 1'b0);
    chk("lit_ill_pre", ia.data_o, 64'h55);
    src_a[0] = 32'h66;
    step_a(1'b1, 2'd3, 1'b1, 1'b0);
    chk("lit_ill_data", ia.data_o, 64'h55);
    chk("lit_ill_err", ia.sel_err_o, 1'b1);
    step_a(1'b1, 2'd3, 1'b1, 1'b0);
    chk("lit_ill_hold", ia.data_o, 64'h55);
    step_a(1'b0, 2'd3, 1'b1, 1'b0);
    chk("lit_ill_err_off", ia.sel_err_o, 1'b0);

    // Flush while full, with an upstream operand offered.
    src_a[1] = 32'hB0;
    step_a(1'b1, 2'd1, 1'b0, 1'b0);
    src_a[1] = 32'hB1;
    step_a(1'b1, 2'd1, 1'b0, 1'b0);
    chk("lit_fl_full", ia.ready_o, 1'b0);
    src_a[1] = 32'hB2;
    step_a(1'b1, 2'd1, 1'b0, 1'b1);
    chk("lit_fl_vld", ia.valid_o, 1'b0);
    chk("lit_fl_rdy", ia.ready_o, 1'b1);
    step_a(1'b0, 2'd0, 1'b1, 1'b0);
    chk("lit_fl_after", ia.valid_o, 1'b0);

    // Flush coinciding with an illegal-select accept: no error, nothing kept.
    src_a[0] = 32'hC0;
    step_a(1'b1, 2'd0, 1'b0, 1'b0);
    step_a(1'b1, 2'd3, 1'b0, 1'b1);
    chk("lit_flacc_vld", ia.valid_o, 1'b0);
    chk("lit_flacc_err", ia.sel_err_o, 1'b0);
    step_a(1'b0, 2'd0, 1'b1, 1'b0);

    // Asynchronous reset while full.
    src_a[2] = 32'hE0;
    step_a(1'b1, 2'd2, 1'b0, 1'b0);
    src_a[2] = 32'hE1;
    step_a(1'b1, 2'd2, 1'b0, 1'b0);
    chk("lit_ar_full", ia.valid_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    chk("lit_ar_vld", ia.valid_o, 1'b0);
    chk("lit_ar_data", ia.data_o, 64'h0);
    ia.valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    step_a(1'b0, 2'd0, 1'b1, 1'b0);
    chk("lit_ar_rdy", ia.ready_o, 1'b1);

    // Wide five-source build.
    step_b(1'b1, 3'd4, 1'b1);
    chk("lit_b_src4", ib.data_o, 64'hDEAD_BEEF_0000_0001);
    chk("lit_b_err4", ib.sel_err_o, 1'b0);
    for (int s = 5; s < 8; s++) begin
      step_b(1'b1, 3'(s), 1'b1);
      chk("lit_b_err_ill", ib.sel_err_o, 1'b1);
      chk("lit_b_replay", ib.data_o, 64'hDEAD_BEEF_0000_0001);
    end
    step_b(1'b1, 3'd0, 1'b1);
    chk("lit_b_src0", ib.data_o, 64'h1000_0000_0000_0000);
    chk("lit_b_err0", ib.sel_err_o, 1'b0);
    step_b(1'b0, 3'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fwd_reg.md
Name: operand_fwd_reg

Overview:
- Parametrised operand-forwarding stage for the pipelined CPU, sitting between ID/EX operand fetch and the ALU input.
- Selects one of NSRC forwarding sources: register file, data memory, previous ALU result, and further sources when NSRC grows.
- Registers the selected operand behind a valid/ready handshake, using a 2-entry skid buffer so EX stalls never drop an operand.
- Adds flush and out-of-range-select handling; the earlier combinational 3-way forward mux had neither.

Parameters:
- WIDTH, 32, operand width in bits.
- NSRC, 3, number of forwarding sources; legal range 2..16.
- SELW, $clog2(NSRC) (minimum 1), select field width.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- data_i  input  NSRC*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
- select_i  input  SELW  source index; 0 = register file, 1 = data memory, 2 = previous ALU result.
- valid_i  input  1  upstream operand valid.
- ready_o  output  1  stage can accept; registered, not combinationally dependent on ready_i.
- flush_i  input  1  discard all buffered operands (branch mispredict / exception).
- data_o  output  WIDTH  operand at buffer head.
- valid_o  output  1  data_o valid.
- ready_i  input  1  downstream (EX) accepts.
- sel_err_o  output  1  one-cycle pulse: an accepted transfer had select_i >= NSRC.

Behaviour:
- Reset (async assert, sync release): both buffer entries invalid; data regs and last_q = 0; valid_o = 0; ready_o = 1; sel_err_o = 0.
- Accept = valid_i & ready_o. The captured value is data_i[select_i] if select_i < NSRC, otherwise last_q.
- last_q updates on every accept with a legal select. On an illegal select, last_q keeps its value (hold semantics) and sel_err_o = 1 in the following cycle.
- Latency: 1 cycle from accept to valid_o when the buffer is empty.
- Throughput: 1 operand/cycle while ready_i = 1.
- Buffer states:
  - EMPTY: valid_o = 0, ready_o = 1.
  - ONE: main entry valid, ready_o = 1.
  - FULL: main + skid valid, ready_o = 0.
- Transitions:
  - EMPTY -> ONE on accept.
  - ONE -> ONE on accept & ready_i (main replaced).
  - ONE -> EMPTY on ready_i with no accept.
  - ONE -> FULL on accept & !ready_i (new data goes to skid).
  - FULL -> ONE on ready_i (skid moves to main).
  - No accept is possible while FULL.
- data_o is always the main entry; ordering is strictly FIFO.
- data_o and valid_o must hold stable while valid_o & !ready_i.
- flush_i, synchronous:
  - Next cycle: both entries invalid, state EMPTY, ready_o = 1.
  - An accept in the same cycle as flush_i is discarded; its sel_err_o pulse is also suppressed.
  - last_q is not cleared by flush.
- Simultaneous accept and drain in ONE: the downstream takes the old main value; the new value becomes main. No bubble.
- Reset mid-transfer: all buffered data is lost; outputs go to reset values immediately, without waiting for a clock edge.
- No arithmetic; widths are exact, with no sign or zero extension.

Decomposition:
- Shared package cpu_fwd_pkg holds:
  - localparams FWD_REG = 0, FWD_MEM = 1, FWD_ALU = 2.
  - Typedef fwd_sel_t for the select field.
  - Used by both the hazard/forwarding control unit and this block.
- One sub-module, pipe_skid_buf (WIDTH-parametrised 2-entry skid buffer with flush). operand_fwd_reg contributes the source mux, last_q hold and error logic in front of it.

Test Plan:
- Reset then stream, ready_i = 1: select_i = 0, 1, 2 with sources 0x11 / 0x22 / 0x33 over consecutive cycles -> data_o = 0x11, 0x22, 0x33 one cycle later each; valid_o continuously 1; ready_o stays 1.
- Backpressure: ready_i = 0 for 3 cycles while sending 0xA0, 0xA1, 0xA2 -> ready_o falls after the 2nd accept; 0xA2 is held upstream. On release, outputs are 0xA0, 0xA1, 0xA2 in order with no loss or duplication.
- Illegal select, NSRC = 3, select_i = 3 after a legal 0x55 capture -> output 0x55; sel_err_o pulses exactly 1 cycle; last_q unchanged.
- Flush while FULL with an accept attempted in the same cycle -> next cycle valid_o = 0, ready_o = 1; the flushed values never appear on data_o.
- Async reset asserted mid-clock while FULL -> valid_o = 0 and data_o = 0 before the next edge; ready_o = 1 after release.
- Parametrised build, NSRC = 5, WIDTH = 64: select_i = 4 with source 4 = 0xDEAD_BEEF_0000_0001 -> data_o shows that value; select_i = 5..7 flag sel_err_o.
